// File: rtl/kbd_pkg.sv
// +----------------------------------------------------------------------------+
// | kbd_pkg: shared scan-code constants, tracker FSM encoding, scan->ASCII map  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package kbd_pkg;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] ASCII_NONE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  // Set-2 make codes for letters, digits, space and enter; all else unmapped.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
    logic [7:0] a;
    case (sc)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
      default: a = ASCII_NONE;
    endcase
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_ascii_rom.sv
// +----------------------------------------------------------------------------+
// | ps2_ascii_rom: combinational set-2 scan code -> ASCII, unmapped -> 8'h00    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_ascii_rom
  import kbd_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic [7:0] ascii
);

  assign ascii = scan_to_ascii(scan_code);

endmodule

`default_nettype wire

// File: rtl/ps2_key_tracker.sv
// +----------------------------------------------------------------------------+
// | ps2_key_tracker: PS/2 set-2 make/break tracker with held-key outputs.       |
// | KBD_EXT_PREFIX_EN enables E0 extended-prefix handling.   Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_key_tracker
  import kbd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter int          CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       scan_data,
  input  logic             scan_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count,
  output logic             evt_valid
);

  kbd_state_e       state_q, state_d;
  logic [23:0]      tmo_q, tmo_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic [7:0]       key_ascii_q, key_ascii_d;
  logic             key_down_q, key_down_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             evt_valid_q, evt_valid_d;

  logic [7:0] rom_ascii;
  logic       is_brk, is_ext;
  logic       do_make, do_break, byte_ext;

  ps2_ascii_rom u_rom (
    .scan_code (scan_data),
    .ascii     (rom_ascii)
  );

  assign is_brk = (scan_data == SC_BREAK);
  assign is_ext = (scan_data == SC_EXT);

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_ascii_d   = key_ascii_q;
    key_down_d    = key_down_q;
    press_count_d = press_count_q;
    evt_valid_d   = 1'b0;
    do_make       = 1'b0;
    do_break      = 1'b0;
    byte_ext      = 1'b0;

    // Prefix timeout; a byte arriving on the expiry cycle overrides it below.
    if (state_q == ST_IDLE || scan_valid) begin
      tmo_d = 24'd0;
    end else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
      tmo_d   = 24'd0;
      state_d = ST_IDLE;
    end else begin
      tmo_d = tmo_q + 24'd1;
    end

    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (is_brk) begin
            state_d = ST_BRK;
`ifdef KBD_EXT_PREFIX_EN
          end else if (is_ext) begin
            state_d = ST_EXT;
`endif
          end else begin
            do_make = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_BRK;
          if (!is_brk) begin
            do_break = 1'b1;
            state_d  = ST_IDLE;
          end
        end
`ifdef KBD_EXT_PREFIX_EN
        ST_EXT: begin
          byte_ext = 1'b1;
          state_d  = ST_EXT;
          if (is_brk) begin
            state_d = ST_EXT_BRK;
          end else if (!is_ext) begin
            do_make = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          byte_ext = 1'b1;
          state_d  = ST_EXT_BRK;
          if (!is_brk) begin
            do_break = 1'b1;
            state_d  = ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    if (do_make && (!key_down_q || {byte_ext, scan_data} != {key_ext_q, key_code_q})) begin
      key_code_d    = scan_data;
      key_ext_d     = byte_ext;
      key_ascii_d   = byte_ext ? ASCII_NONE : rom_ascii;
      key_down_d    = 1'b1;
      press_count_d = press_count_q + CNT_W'(1);
      evt_valid_d   = 1'b1;
    end

    if (do_break && key_down_q && {byte_ext, scan_data} == {key_ext_q, key_code_q}) begin
      key_down_d  = 1'b0;
      evt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tmo_q         <= 24'd0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_ascii_q   <= 8'h00;
      key_down_q    <= 1'b0;
      press_count_q <= '0;
      evt_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_ascii_q   <= key_ascii_d;
      key_down_q    <= key_down_d;
      press_count_q <= press_count_d;
      evt_valid_q   <= evt_valid_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_ascii   = key_ascii_q;
  assign key_down    = key_down_q;
  assign press_count = press_count_q;
  assign evt_valid   = evt_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
// +----------------------------------------------------------------------------+
// | tb_ps2_key_tracker: scoreboard bench with a behavioural key-state model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ps2_key_tracker;

  localparam logic [23:0] TMO = 24'd16;
  localparam int          TMO_I = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_down;
  logic [7:0] press_count;
  logic       evt_valid;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_data   (scan_data),
    .scan_valid  (scan_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_ascii   (key_ascii),
    .key_down    (key_down),
    .press_count (press_count),
    .evt_valid   (evt_valid)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic [7:0] ascii;
    logic       down;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   tests = 0;
  int   fails = 0;

`ifdef KBD_EXT_PREFIX_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  // Reference model: what key the user is holding, described at event level.
  logic [7:0] ascii_tbl [256];
  bit         m_brk, m_ext;
  logic [7:0] m_code, m_ascii;
  bit         m_ext_h, m_down;
  int         m_cnt;

  task automatic build_table();
    logic [7:0] codes [38];
    string      chars;
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
              8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
              8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
              8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
              8'h29, 8'h5A};
    chars = "abcdefghijklmnopqrstuvwxyz0123456789 ";
    for (int i = 0; i < 256; i++) ascii_tbl[i] = 8'h00;
    for (int i = 0; i < 37; i++) ascii_tbl[codes[i]] = chars[i];
    ascii_tbl[codes[37]] = 8'h0D;
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_code = 8'h00; m_ascii = 8'h00;
    m_ext_h = 0; m_down = 0; m_cnt = 0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.code = m_code; e.ext = m_ext_h; e.ascii = m_ascii; e.down = m_down; e.cnt = 8'(m_cnt);
    return e;
  endfunction

  task automatic model_make(input logic [7:0] c, input bit e);
    if (!m_down || c != m_code || e != m_ext_h) begin
      m_code = c; m_ext_h = e; m_down = 1;
      m_ascii = e ? 8'h00 : ascii_tbl[c];
      m_cnt = (m_cnt + 1) % 256;
      exp_q.push_back(model_snapshot());
    end
  endtask

  task automatic model_break(input logic [7:0] c, input bit e);
    if (m_down && c == m_code && e == m_ext_h) begin
      m_down = 0;
      exp_q.push_back(model_snapshot());
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_brk) begin
      if (b != 8'hF0) begin
        model_break(b, m_ext);
        m_brk = 0; m_ext = 0;
      end
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        model_make(b, 1);
        m_ext = 0;
      end
    end else begin
      if (b == 8'hF0) m_brk = 1;
      else if (EXT_EN && b == 8'hE0) m_ext = 1;
      else model_make(b, 0);
    end
  endtask

  // Each byte is valid for one cycle, followed by `idle` cycles with no byte.
  task automatic send(input logic [7:0] b, input int idle);
    model_byte(b);
    scan_data  = b;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    if (idle >= TMO_I) begin m_brk = 0; m_ext = 0; end
  endtask

  task automatic check_outputs(input string name, input exp_t want, input logic want_evt);
    mon_a = '{key_code, key_ext, key_ascii, key_down, press_count};
    tests++;
    if (mon_a !== want || evt_valid !== want_evt) begin
      fails++;
      $display("FAIL %s: got code=%h ext=%b ascii=%h down=%b cnt=%0d evt=%b, want code=%h ext=%b ascii=%h down=%b cnt=%0d evt=%b",
               name, mon_a.code, mon_a.ext, mon_a.ascii, mon_a.down, mon_a.cnt, evt_valid,
               want.code, want.ext, want.ascii, want.down, want.cnt, want_evt);
    end
  endtask

  // Monitor: every evt_valid pulse must match the oldest predicted event.
  always @(negedge clk) begin
    if (!rst && evt_valid) begin
      tests++;
      mon_a = '{key_code, key_ext, key_ascii, key_down, press_count};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_evt: got code=%h ext=%b down=%b cnt=%0d, want no event",
                 mon_a.code, mon_a.ext, mon_a.down, mon_a.cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          fails++;
          $display("FAIL evt_outputs: got code=%h ext=%b ascii=%h down=%b cnt=%0d, want code=%h ext=%b ascii=%h down=%b cnt=%0d",
                   mon_a.code, mon_a.ext, mon_a.ascii, mon_a.down, mon_a.cnt,
                   mon_e.code, mon_e.ext, mon_e.ascii, mon_e.down, mon_e.cnt);
        end
      end
    end
  end

  logic [7:0] pool [8];
  logic [7:0] b;

  initial begin
    pool = '{8'h1C, 8'h32, 8'h21, 8'h75, 8'hE0, 8'hF0, 8'hF0, 8'h5A};
    build_table();
    model_reset();
    rst = 1'b1; scan_valid = 1'b0; scan_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_state", model_snapshot(), 1'b0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Press and release 'a'
    send(8'h1C, 2);
    check_outputs("make_a_held", model_snapshot(), 1'b0);
    send(8'hF0, 1); send(8'h1C, 2);
    check_outputs("break_a", model_snapshot(), 1'b0);

    // Typematic repeats are silent
    repeat (5) send(8'h1C, 0);
    send(8'hF0, 0); send(8'h1C, 2);

    // Second key takes over; stale break of the first is ignored
    send(8'h1C, 1); send(8'h32, 1); send(8'hF0, 1); send(8'h32, 1);
    send(8'hF0, 1); send(8'h1C, 2);
    check_outputs("after_b_release", model_snapshot(), 1'b0);

    // Prefix timeout boundary: one cycle short keeps the prefix, full length drops it
    send(8'hF0, TMO_I + 4); send(8'h1C, 2);
    send(8'hF0, TMO_I - 1); send(8'h1C, 2);
    send(8'h1C, 1); send(8'hF0, TMO_I); send(8'h1C, 2);
    check_outputs("timeout_typematic", model_snapshot(), 1'b0);
    send(8'hF0, 0); send(8'hF0, 0); send(8'h1C, 2);

    // Extended key make/break (or plain E0 make when prefix handling is off)
    send(8'hE0, 0); send(8'h75, 2);
    check_outputs("ext_make", model_snapshot(), 1'b0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 2);
    send(8'hE0, 0); send(8'hE0, 1); send(8'h6B, 1);

    // Wrap of the press counter
    for (int i = 0; i < 256; i++) send((i % 2) ? 8'h21 : 8'h23, 0);
    repeat (2) begin @(posedge clk); #1; end
    check_outputs("count_wrap", model_snapshot(), 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      send(b, ($urandom_range(0, 19) == 0) ? TMO_I + 4 : $urandom_range(0, 3));
    end
    repeat (3) begin @(posedge clk); #1; end
    check_outputs("random_final", model_snapshot(), 1'b0);

    // Reset in the middle of a break sequence
    send(8'h1C, 1); send(8'hF0, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_reset", model_snapshot(), 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h1C, 2);
    check_outputs("make_after_reset", model_snapshot(), 1'b0);

    repeat (5) begin @(posedge clk); #1; end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_evt: got %0d predicted events never seen, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
